shifter_iterative: RTL

- Sequential, area-lean counterpart of the single-cycle combinational barrel shifter.
- Uses the same 3-bit control encoding and the same shift semantics.
- Accepts one request through a valid/ready handshake, shifts one position per clock, and returns the result through a second valid/ready handshake.
- Used where a full WIDTH×WIDTH mux array is too costly and multi-cycle latency is acceptable.

---
 rtl/shifter_iterative.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/shifter_iterative.sv
// Iterative shifter: one request in, one shift step per clock, one result out.
// Same 3-bit op encoding and results as the single-cycle barrel shifter.
//
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_valid / o_ready   request handshake (o_ready high only when idle)
//   i_data, i_ctrl      operand and op code
//   i_shift_amount      shift count (AW bits)
//   o_valid / i_ready   result handshake
//   o_data              registered result
//   o_busy              high while shifting or holding a result
//
// Optional: define SHIFTER_ITER_STEP4_EN to move 4 positions per cycle
// while at least 4 steps remain. Results are identical either way.
module shifter_iterative #(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_ctrl,
  input  logic [AW-1:0]    i_shift_amount,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  localparam logic [AW-1:0] WCNT = AW'(WIDTH);

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    load_cnt;

  function automatic logic [WIDTH-1:0] step1(
    input logic [WIDTH-1:0] r,
    input logic [2:0]       op
  );
    logic [WIDTH-1:0] n;
    n = r;
    case (op)
      3'b001:  n = {1'b0, r[WIDTH-1:1]};
      3'b010:  n = {r[WIDTH-1], r[WIDTH-1:1]};
      3'b011:  n = {r[0], r[WIDTH-1:1]};
      3'b100:  n = {r[WIDTH-2:0], 1'b0};
      3'b110:  n = {r[WIDTH-2:0], r[WIDTH-1]};
      default: n = r;
    endcase
    return n;
  endfunction

`ifdef SHIFTER_ITER_STEP4_EN
  // Four chained single steps flatten into one 4-position move.
  function automatic logic [WIDTH-1:0] step4(
    input logic [WIDTH-1:0] r,
    input logic [2:0]       op
  );
    return step1(step1(step1(step1(r, op), op), op), op);
  endfunction
`endif

  // Logical shifts saturate at WIDTH (result all zero);
  // arithmetic and rotates wrap modulo WIDTH.
  always_comb begin
    load_cnt = '0;
    case (i_ctrl)
      3'b001, 3'b100:
        load_cnt = (i_shift_amount > WCNT) ? WCNT : i_shift_amount;
      3'b010, 3'b011, 3'b110:
        load_cnt = i_shift_amount % WCNT;
      default:
        load_cnt = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          data_d  = i_data;
          op_d    = i_ctrl;
          cnt_d   = load_cnt;
          state_d = (load_cnt != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
`ifdef SHIFTER_ITER_STEP4_EN
        if (32'(cnt_q) >= 4) begin
          data_d = step4(data_q, op_q);
          cnt_d  = cnt_q - AW'(4);
        end else begin
          data_d = step1(data_q, op_q);
          cnt_d  = cnt_q - AW'(1);
        end
`else
        data_d = step1(data_q, op_q);
        cnt_d  = cnt_q - AW'(1);
`endif
        if (cnt_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      op_q    <= op_d;
    end
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_busy  = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign o_data  = data_q;

endmodule
